pulse_tx_pacer: RTL and testbench

//   Source-side (clka domain) transmitter for the pulse synchronizers.

---
 rtl/pulse_tx_pacer_if.sv | 22 ++
 rtl/pulse_tx_pacer.sv | 85 ++++++++
 tb/tb_pulse_tx_pacer.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/pulse_tx_pacer_if.sv
// Handshake bundle between an event source and the pulse transmitter pacer.
// The master side raises requests and flush; the slave side returns pulses and status.
interface pulse_tx_pacer_if #(
  parameter int unsigned CNT_W = 4
);
  logic             req_in;
  logic             flush;
  logic             pulse_out;
  logic [CNT_W-1:0] pending;
  logic             busy;
  logic             overflow;

  modport master (
    output req_in, flush,
    input  pulse_out, pending, busy, overflow
  );

  modport slave (
    input  req_in, flush,
    output pulse_out, pending, busy, overflow
  );
endinterface

// File: rtl/pulse_tx_pacer.sv
// Source-domain pulse pacer: queues one-cycle events and replays them as
// single-cycle pulses separated by at least GAP_CYCLES low cycles.
module pulse_tx_pacer #(
  parameter int unsigned GAP_CYCLES = 4,
  parameter int unsigned CNT_W      = 4
) (
  input  logic             clka,
  input  logic             resetb_a,
  pulse_tx_pacer_if.slave  io
);

  localparam int unsigned GCW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [CNT_W-1:0] MAX_PEND = '1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PULSE = 2'd1,
    GAP   = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [GCW-1:0]   gap_cnt_q, gap_cnt_d;
  logic [CNT_W-1:0] pending_q, pending_d;
  logic             overflow_q, overflow_d;
  logic             issue;

  always_ff @(posedge clka or negedge resetb_a) begin
    if (!resetb_a) begin
      state_q    <= IDLE;
      gap_cnt_q  <= '0;
      pending_q  <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      gap_cnt_q  <= gap_cnt_d;
      pending_q  <= pending_d;
      overflow_q <= overflow_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    gap_cnt_d  = gap_cnt_q;
    pending_d  = pending_q;
    overflow_d = overflow_q;

    // A flush cycle never launches a new pulse; the backlog it clears is gone.
    issue = !io.flush && (pending_q != '0) &&
            ((state_q == IDLE) || ((state_q == GAP) && (gap_cnt_q == '0)));

    unique case (state_q)
      IDLE: begin
        if (issue) state_d = PULSE;
      end
      PULSE: begin
        state_d   = GAP;
        gap_cnt_d = GCW'(GAP_CYCLES - 1);
      end
      GAP: begin
        if (gap_cnt_q != '0) begin
          gap_cnt_d = gap_cnt_q - GCW'(1);
        end else begin
          state_d = issue ? PULSE : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (io.flush) begin
      pending_d  = '0;
      overflow_d = 1'b0;
    end else if (io.req_in && !issue) begin
      if (pending_q == MAX_PEND) overflow_d = 1'b1;
      else                       pending_d  = pending_q + CNT_W'(1);
    end else if (!io.req_in && issue) begin
      pending_d = pending_q - CNT_W'(1);
    end
  end

  assign io.pulse_out = (state_q == PULSE);
  assign io.pending   = pending_q;
  assign io.busy      = (state_q != IDLE) || (pending_q != '0);
  assign io.overflow  = overflow_q;

endmodule

// File: tb/tb_pulse_tx_pacer.sv
// Directed checks of pulse_tx_pacer with GAP_CYCLES=4, CNT_W=4; cycle 0 is
// the first cycle after reset release, outputs sampled 1ns after each edge.
module tb_pulse_tx_pacer;

  localparam int unsigned GAP = 4;
  localparam int unsigned CW  = 4;

  logic clka     = 1'b0;
  logic resetb_a = 1'b0;

  always #5 clka = ~clka;

  pulse_tx_pacer_if #(.CNT_W(CW)) io ();

  pulse_tx_pacer #(
    .GAP_CYCLES (GAP),
    .CNT_W      (CW)
  ) dut (
    .clka     (clka),
    .resetb_a (resetb_a),
    .io       (io)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%0d want=%0d", tag, cyc, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clka);
    #1;
    cyc++;
  endtask

  task automatic do_reset();
    resetb_a  = 1'b0;
    io.req_in = 1'b0;
    io.flush  = 1'b0;
    repeat (2) @(posedge clka);
    #1;
    chk("rst_pulse",    32'(io.pulse_out), 32'd0);
    chk("rst_pending",  32'(io.pending),   32'd0);
    chk("rst_busy",     32'(io.busy),      32'd0);
    chk("rst_overflow", 32'(io.overflow),  32'd0);
    @(negedge clka);
    resetb_a = 1'b1;
    @(posedge clka);
    #1;
    cyc = 0;
  endtask

  initial begin
    int pulses;
    int last;

    // 1: single request, two-cycle latency, busy window
    do_reset();
    while (cyc <= 20) begin
      chk("s1_pulse", 32'(io.pulse_out), 32'(cyc == 12));
      chk("s1_busy",  32'(io.busy),      32'(cyc >= 11 && cyc <= 16));
      io.req_in = (cyc == 10);
      step();
    end

    // 2: three back-to-back requests, paced at 5 cycles
    do_reset();
    while (cyc <= 30) begin
      chk("s2_pulse", 32'(io.pulse_out), 32'(cyc == 12 || cyc == 17 || cyc == 22));
      if (cyc == 13) chk("s2_pend13", 32'(io.pending), 32'd2);
      if (cyc >= 22) chk("s2_pend0",  32'(io.pending), 32'd0);
      io.req_in = (cyc >= 10 && cyc <= 12);
      step();
    end

    // 3: 30-cycle request burst saturates at 15; 9 requests dropped
    do_reset();
    pulses = 0;
    last   = -1;
    while (cyc <= 130) begin
      if (io.pulse_out) begin
        if (last >= 0) chk("s3_spacing", 32'(cyc - last), 32'd5);
        last = cyc;
        pulses++;
      end
      chk("s3_overflow", 32'(io.overflow), 32'(cyc >= 30));
      if (cyc == 29 || cyc == 40) chk("s3_pend_max", 32'(io.pending), 32'd15);
      io.req_in = (cyc >= 10 && cyc <= 39);
      step();
    end
    chk("s3_pulses",   32'(pulses),     32'd21);
    chk("s3_drained",  32'(io.pending), 32'd0);
    chk("s3_idle",     32'(io.busy),    32'd0);

    // 4: flush during a gap; in-flight spacing completes, backlog discarded
    do_reset();
    while (cyc <= 30) begin
      chk("s4_pulse", 32'(io.pulse_out), 32'(cyc == 12));
      if (cyc == 15) chk("s4_pend15", 32'(io.pending), 32'd4);
      if (cyc == 16) begin
        chk("s4_pend16", 32'(io.pending),  32'd0);
        chk("s4_ovf16",  32'(io.overflow), 32'd0);
      end
      if (cyc >= 17) chk("s4_busy", 32'(io.busy), 32'd0);
      io.req_in = (cyc >= 10 && cyc <= 14);
      io.flush  = (cyc == 15);
      step();
    end
    io.flush = 1'b0;

    // 5: asynchronous reset in the middle of the pulse cycle
    do_reset();
    while (cyc < 12) begin
      io.req_in = (cyc == 10);
      step();
    end
    io.req_in = 1'b0;
    chk("s5_pulse_pre", 32'(io.pulse_out), 32'd1);
    #2;
    resetb_a = 1'b0;
    #1;
    chk("s5_pulse_async", 32'(io.pulse_out), 32'd0);
    chk("s5_pend_async",  32'(io.pending),   32'd0);
    chk("s5_busy_async",  32'(io.busy),      32'd0);
    @(negedge clka);
    resetb_a = 1'b1;
    repeat (20) begin
      step();
      chk("s5_quiet", 32'(io.pulse_out), 32'd0);
    end

    // 6: request arrives while full but in an issue cycle -> no drop
    do_reset();
    while (cyc <= 40) begin
      chk("s6_overflow", 32'(io.overflow), 32'd0);
      if (cyc >= 29 && cyc <= 32) chk("s6_pend", 32'(io.pending), 32'd15);
      if (cyc == 32) chk("s6_pulse32", 32'(io.pulse_out), 32'd1);
      io.req_in = (cyc >= 10 && cyc <= 28) || (cyc == 31);
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
